// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between requesters A and B,
// with an optional post-reset sweep that fills the array with INIT_VALUE.

module sram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2048,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rd_o_wr,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // One access per clock: write when rd_o_wr=1, otherwise registered read.
  always_ff @(posedge clk) begin
    if (rd_o_wr) begin
      r_mem[addr] <= i_data;
    end else begin
      o_data <= r_mem[addr];
    end
  end

endmodule

module sram_arbiter #(
  parameter int               WIDTH          = 8,
  parameter int               DEPTH          = 2048,
  parameter bit               CLEAR_ON_RESET = 1'b1,
  parameter logic [WIDTH-1:0] INIT_VALUE     = {WIDTH{1'b0}},
  localparam int              AW             = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_req,
  input  logic             a_we,
  input  logic [AW-1:0]    a_addr,
  input  logic [WIDTH-1:0] a_wdata,
  output logic             a_gnt,
  output logic             a_rvalid,
  output logic [WIDTH-1:0] a_rdata,
  input  logic             b_req,
  input  logic             b_we,
  input  logic [AW-1:0]    b_addr,
  input  logic [WIDTH-1:0] b_wdata,
  output logic             b_gnt,
  output logic             b_rvalid,
  output logic [WIDTH-1:0] b_rdata,
  output logic             init_done
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [AW-1:0]    r_cnt;
  logic [AW-1:0]    w_cnt_nxt;
  logic             r_last_b;
  logic             r_a_rvalid;
  logic             r_b_rvalid;
  logic             w_a_gnt;
  logic             w_b_gnt;
  logic             w_sram_wr;
  logic [AW-1:0]    w_sram_addr;
  logic [WIDTH-1:0] w_sram_wdata;
  logic [WIDTH-1:0] w_sram_rdata;

  sram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_sram (
    .clk     (clk),
    .rd_o_wr (w_sram_wr),
    .addr    (w_sram_addr),
    .i_data  (w_sram_wdata),
    .o_data  (w_sram_rdata)
  );

  // Next-state, round-robin grant and SRAM drive; no grant while in reset.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_a_gnt      = 1'b0;
    w_b_gnt      = 1'b0;
    w_sram_wr    = 1'b0;
    w_sram_addr  = {AW{1'b0}};
    w_sram_wdata = {WIDTH{1'b0}};
    if (!rst_n) begin
      w_state_nxt = r_state;
    end else begin
      case (r_state)
        ST_INIT: begin
          w_sram_wr    = 1'b1;
          w_sram_addr  = r_cnt;
          w_sram_wdata = INIT_VALUE;
          w_cnt_nxt    = r_cnt + AW'(1'b1);
          if (r_cnt == LAST_ADDR) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_INIT;
          end
        end
        ST_RUN: begin
          // r_last_b=1 means B won last, so A takes the next contention.
          if (a_req && (!b_req || r_last_b)) begin
            w_a_gnt = 1'b1;
          end else if (b_req) begin
            w_b_gnt = 1'b1;
          end else begin
            w_a_gnt = 1'b0;
            w_b_gnt = 1'b0;
          end
          if (w_a_gnt) begin
            w_sram_wr    = a_we;
            w_sram_addr  = a_addr;
            w_sram_wdata = a_wdata;
          end else if (w_b_gnt) begin
            w_sram_wr    = b_we;
            w_sram_addr  = b_addr;
            w_sram_wdata = b_wdata;
          end else begin
            w_sram_wr    = 1'b0;
            w_sram_addr  = {AW{1'b0}};
            w_sram_wdata = {WIDTH{1'b0}};
          end
        end
        default: begin
          w_state_nxt = ST_INIT;
        end
      endcase
    end
  end

  // State, sweep counter, round-robin history and read-valid pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= CLEAR_ON_RESET ? ST_INIT : ST_RUN;
      r_cnt      <= {AW{1'b0}};
      r_last_b   <= 1'b1;
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_a_gnt) begin
        r_last_b <= 1'b0;
      end else if (w_b_gnt) begin
        r_last_b <= 1'b1;
      end else begin
        r_last_b <= r_last_b;
      end
      r_a_rvalid <= w_a_gnt & ~a_we;
      r_b_rvalid <= w_b_gnt & ~b_we;
    end
  end

  assign a_gnt    = w_a_gnt;
  assign b_gnt    = w_b_gnt;
  assign a_rvalid = r_a_rvalid;
  assign b_rvalid = r_b_rvalid;
  assign a_rdata  = r_a_rvalid ? w_sram_rdata : {WIDTH{1'b0}};
  assign b_rdata  = r_b_rvalid ? w_sram_rdata : {WIDTH{1'b0}};
  // Decoded from the state register so a no-sweep build is ready right after reset.
  assign init_done = rst_n & (r_state == ST_RUN);

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: a sweeping instance (INIT_VALUE A5) and a no-sweep instance.
module tb_sram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [3:0] a_addr = 4'd0, b_addr = 4'd0;
  logic [7:0] a_wdata = 8'h00, b_wdata = 8'h00;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid, init_done;
  logic [7:0] a_rdata, b_rdata;

  logic       z_rst_n = 1'b0;
  logic       z_a_req = 1'b0, z_a_we = 1'b0, z_b_req = 1'b0, z_b_we = 1'b0;
  logic [3:0] z_a_addr = 4'd0, z_b_addr = 4'd0;
  logic [7:0] z_a_wdata = 8'h00, z_b_wdata = 8'h00;
  logic       z_a_gnt, z_a_rvalid, z_b_gnt, z_b_rvalid, z_init_done;
  logic [7:0] z_a_rdata, z_b_rdata;

  sram_arbiter #(.WIDTH(8), .DEPTH(16), .CLEAR_ON_RESET(1'b1), .INIT_VALUE(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .init_done(init_done)
  );

  sram_arbiter #(.WIDTH(8), .DEPTH(16), .CLEAR_ON_RESET(1'b0), .INIT_VALUE(8'h00)) dut_nc (
    .clk(clk), .rst_n(z_rst_n),
    .a_req(z_a_req), .a_we(z_a_we), .a_addr(z_a_addr), .a_wdata(z_a_wdata),
    .a_gnt(z_a_gnt), .a_rvalid(z_a_rvalid), .a_rdata(z_a_rdata),
    .b_req(z_b_req), .b_we(z_b_we), .b_addr(z_b_addr), .b_wdata(z_b_wdata),
    .b_gnt(z_b_gnt), .b_rvalid(z_b_rvalid), .b_rdata(z_b_rdata),
    .init_done(z_init_done)
  );

  typedef struct {
    bit         port_b;
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t       sb[$];
  exp_t       m_e;
  logic [7:0] model [16];
  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  bit         mon_en = 1'b0;
  bit         m_ea, m_eb;
  logic [7:0] m_da, m_db;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected read response, due in the cycle after the grant being observed now.
  task automatic push_read(input bit pb, input logic [3:0] addr);
    exp_t e;
    e.port_b = pb;
    e.data   = model[addr];
    e.due    = cyc + 1;
    sb.push_back(e);
  endtask

  // Response monitor: every cycle both ports must match the scoreboard exactly.
  always @(negedge clk) begin
    if (mon_en) begin
      m_ea = 1'b0; m_eb = 1'b0; m_da = 8'h00; m_db = 8'h00;
      while (sb.size() > 0 && sb[0].due < cyc) begin
        m_e = sb.pop_front();
        n_cmp++; n_err++;
        $display("FAIL sb_stale: response due cycle %0d never checked", m_e.due);
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        m_e = sb.pop_front();
        if (m_e.port_b) begin m_eb = 1'b1; m_db = m_e.data; end
        else            begin m_ea = 1'b1; m_da = m_e.data; end
      end
      n_cmp++;
      if (a_rvalid !== m_ea || a_rdata !== m_da) begin
        n_err++;
        $display("FAIL a_rsp cyc %0d: got v=%b d=%h, expected v=%b d=%h", cyc, a_rvalid, a_rdata, m_ea, m_da);
      end
      n_cmp++;
      if (b_rvalid !== m_eb || b_rdata !== m_db) begin
        n_err++;
        $display("FAIL b_rsp cyc %0d: got v=%b d=%h, expected v=%b d=%h", cyc, b_rvalid, b_rdata, m_eb, m_db);
      end
    end
  end

  task automatic test_reset();
    a_req = 1'b1; a_we = 1'b0; a_addr = 4'd3;
    repeat (2) @(posedge clk);
    #1 mon_en = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (a_gnt !== 1'b0 || b_gnt !== 1'b0 || init_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outs: got a_gnt=%b b_gnt=%b init_done=%b, expected 0 0 0", a_gnt, b_gnt, init_done);
    end
    for (int i = 0; i < 16; i++) model[i] = 8'hA5;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      n_cmp++;
      if (init_done !== 1'b0 || a_gnt !== 1'b0) begin
        n_err++;
        $display("FAIL sweep_hold %0d: got init_done=%b a_gnt=%b, expected 0 0", i, init_done, a_gnt);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_cmp++;
    if (init_done !== 1'b1 || a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
      n_err++;
      $display("FAIL first_run: got init_done=%b a_gnt=%b b_gnt=%b, expected 1 1 0", init_done, a_gnt, b_gnt);
    end
    push_read(1'b0, 4'd3);
    @(posedge clk); #1 a_req = 1'b0;
  endtask

  task automatic test_write_read();
    a_req = 1'b1; a_we = 1'b1; a_addr = 4'd7; a_wdata = 8'h3C;
    @(negedge clk);
    n_cmp++;
    if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
      n_err++;
      $display("FAIL wr_gnt: got a_gnt=%b b_gnt=%b, expected 1 0", a_gnt, b_gnt);
    end
    model[7] = 8'h3C;
    @(posedge clk); #1 a_we = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (a_gnt !== 1'b1) begin
      n_err++;
      $display("FAIL rd_gnt: got a_gnt=%b, expected 1", a_gnt);
    end
    push_read(1'b0, 4'd7);
    @(posedge clk); #1 a_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (a_gnt !== 1'b0 || b_gnt !== 1'b0) begin
      n_err++;
      $display("FAIL idle_gnt: got a_gnt=%b b_gnt=%b, expected 0 0", a_gnt, b_gnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_b_only();
    b_req = 1'b1; b_we = 1'b1; b_addr = 4'd2; b_wdata = 8'h5A;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (b_gnt !== 1'b1 || a_gnt !== 1'b0) begin
        n_err++;
        $display("FAIL b_only %0d: got a_gnt=%b b_gnt=%b, expected 0 1", i, a_gnt, b_gnt);
      end
      if (i == 0) model[2] = 8'h5A;
      else        push_read(1'b1, 4'd2);
      @(posedge clk); #1 b_we = 1'b0;
    end
  endtask

  task automatic test_contention();
    bit exp_a;
    a_req = 1'b1; a_we = 1'b0; a_addr = 4'd1;
    b_req = 1'b1; b_we = 1'b0; b_addr = 4'd2;
    for (int i = 0; i < 6; i++) begin
      exp_a = (i % 2) == 0;
      @(negedge clk);
      n_cmp++;
      if (a_gnt !== exp_a || b_gnt !== !exp_a) begin
        n_err++;
        $display("FAIL rr %0d: got a_gnt=%b b_gnt=%b, expected %b %b", i, a_gnt, b_gnt, exp_a, !exp_a);
      end
      if (exp_a) push_read(1'b0, 4'd1);
      else       push_read(1'b1, 4'd2);
      @(posedge clk); #1;
    end
    a_req = 1'b0; b_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    b_req = 1'b1; b_we = 1'b0; b_addr = 4'd7;
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (b_gnt !== 1'b0 || a_gnt !== 1'b0 || init_done !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: got a_gnt=%b b_gnt=%b init_done=%b, expected 0 0 0", a_gnt, b_gnt, init_done);
    end
    for (int i = 0; i < 16; i++) model[i] = 8'hA5;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      n_cmp++;
      if (init_done !== 1'b0 || b_gnt !== 1'b0) begin
        n_err++;
        $display("FAIL resweep %0d: got init_done=%b b_gnt=%b, expected 0 0", i, init_done, b_gnt);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_cmp++;
    if (init_done !== 1'b1 || b_gnt !== 1'b1) begin
      n_err++;
      $display("FAIL resweep_done: got init_done=%b b_gnt=%b, expected 1 1", init_done, b_gnt);
    end
    push_read(1'b1, 4'd7);
    @(posedge clk); #1 b_req = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_no_clear();
    z_a_req = 1'b1; z_a_we = 1'b1; z_a_addr = 4'd4; z_a_wdata = 8'h11;
    z_b_req = 1'b1; z_b_we = 1'b1; z_b_addr = 4'd5; z_b_wdata = 8'h22;
    @(negedge clk);
    n_cmp++;
    if (z_init_done !== 1'b0 || z_a_gnt !== 1'b0 || z_b_gnt !== 1'b0 || z_a_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL nc_reset: got init_done=%b a_gnt=%b b_gnt=%b a_rvalid=%b, expected 0 0 0 0",
               z_init_done, z_a_gnt, z_b_gnt, z_a_rvalid);
    end
    @(posedge clk); #1 z_rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (z_init_done !== 1'b1 || z_a_gnt !== 1'b1 || z_b_gnt !== 1'b0) begin
      n_err++;
      $display("FAIL nc_first: got init_done=%b a_gnt=%b b_gnt=%b, expected 1 1 0", z_init_done, z_a_gnt, z_b_gnt);
    end
    @(posedge clk); #1 z_a_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (z_b_gnt !== 1'b1 || z_a_gnt !== 1'b0) begin
      n_err++;
      $display("FAIL nc_b_gnt: got a_gnt=%b b_gnt=%b, expected 0 1", z_a_gnt, z_b_gnt);
    end
    @(posedge clk); #1 z_b_req = 1'b0; z_a_req = 1'b1; z_a_we = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (z_a_gnt !== 1'b1) begin
      n_err++;
      $display("FAIL nc_a_rd_gnt: got a_gnt=%b, expected 1", z_a_gnt);
    end
    @(posedge clk); #1 z_a_req = 1'b0; z_b_req = 1'b1; z_b_we = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (z_a_rvalid !== 1'b1 || z_a_rdata !== 8'h11 || z_b_gnt !== 1'b1) begin
      n_err++;
      $display("FAIL nc_a_rd: got v=%b d=%h b_gnt=%b, expected 1 11 1", z_a_rvalid, z_a_rdata, z_b_gnt);
    end
    @(posedge clk); #1 z_b_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (z_b_rvalid !== 1'b1 || z_b_rdata !== 8'h22 || z_a_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL nc_b_rd: got v=%b d=%h a_rvalid=%b, expected 1 22 0", z_b_rvalid, z_b_rdata, z_a_rvalid);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_b_only();
    test_contention();
    test_reset_mid();
    test_no_clear();
    repeat (2) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL sb_leftover: got %0d unchecked responses, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
